// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM states and
// instruction field positions.
package cpu_mc_pkg;

    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_MUL  = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_MULT  = 8'h09;
    localparam logic [7:0] OP_LWD   = 8'h0A;
    localparam logic [7:0] OP_LWI   = 8'h0B;
    localparam logic [7:0] OP_SWD   = 8'h0C;
    localparam logic [7:0] OP_SWI   = 8'h0D;

    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 16;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 0;
    localparam int FLD_W   = 8;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == OP_LWD) || (op == OP_LWI);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == OP_SWD) || (op == OP_SWI);
    endfunction

endpackage

// File: rtl/cpu_mc_mult.sv
// Iterative shift-add multiplier producing the low DATA_W bits of A*B.
// DONE marks the final iteration; PRODUCT is valid while DONE is high.
module mult_seq #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              DONE,
    output logic [DATA_W-1:0] PRODUCT
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] step_sum_s;

    // The last iteration's partial sum is exposed directly so the core can
    // write it back on the same edge that would otherwise store it here.
    assign step_sum_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign PRODUCT    = step_sum_s;
    assign DONE       = (cnt_r == CNT_W'(1));

    // Operand latch on START, then one shift-add step per cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
        end else if (START) begin
            mcand_r  <= A;
            mplier_r <= B;
            acc_r    <= '0;
            cnt_r    <= CNT_W'(DATA_W);
        end else if (cnt_r != '0) begin
            acc_r    <= step_sum_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CNT_W'(1);
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle parametrised CPU core: single-cycle ALU/branch ops, an
// iterative multiply and a stalling data-memory access path.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int PC_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    output logic [PC_W-1:0]   PC,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam int IDX_W = $clog2(REG_CNT);

    logic [DATA_W-1:0] regs_r [REG_CNT];
    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [DATA_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              acc_load_r;
    logic              acc_store_r;
    logic [IDX_W-1:0]  acc_rd_r;

    logic [7:0]        op_s;
    logic [7:0]        br_off_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  rs1_idx_s;
    logic [IDX_W-1:0]  rs2_idx_s;
    logic [DATA_W-1:0] rs1_val_s;
    logic [DATA_W-1:0] rs2_val_s;
    logic [DATA_W-1:0] imm_s;
    logic [PC_W-1:0]   pc_plus4_s;
    logic [PC_W-1:0]   br_target_s;
    logic              is_load_s;
    logic              is_store_s;
    logic              addr_from_reg_s;
    logic              mul_start_s;
    logic              mul_done_s;
    logic [DATA_W-1:0] mul_product_s;
    logic              unused_instr_s;

    assign op_s            = INSTRUCTION[OPC_LSB +: FLD_W];
    assign br_off_s        = INSTRUCTION[RD_LSB +: FLD_W];
    assign rd_idx_s        = INSTRUCTION[RD_LSB +: IDX_W];
    assign rs1_idx_s       = INSTRUCTION[RS1_LSB +: IDX_W];
    assign rs2_idx_s       = INSTRUCTION[RS2_LSB +: IDX_W];
    assign rs1_val_s       = regs_r[rs1_idx_s];
    assign rs2_val_s       = regs_r[rs2_idx_s];
    assign imm_s           = DATA_W'(INSTRUCTION[RS2_LSB +: FLD_W]);
    assign pc_plus4_s      = pc_r + PC_W'(3'd4);
    assign br_target_s     = pc_plus4_s + {{(PC_W-10){br_off_s[7]}}, br_off_s, 2'b00};
    assign is_load_s       = is_load_op(op_s);
    assign is_store_s      = is_store_op(op_s);
    assign addr_from_reg_s = (op_s == OP_LWD) || (op_s == OP_SWD);
    assign mul_start_s     = (state_r == ST_EXEC) && (op_s == OP_MULT);
    assign unused_instr_s  = ^INSTRUCTION;
    assign PC              = pc_r;

    mult_seq #(.DATA_W(DATA_W)) u_mult (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (mul_start_s),
        .A       (rs1_val_s),
        .B       (rs2_val_s),
        .DONE    (mul_done_s),
        .PRODUCT (mul_product_s)
    );

    // Memory strobes must rise in the issuing EXEC cycle, so they are decoded
    // from the live instruction there and from the latched request in MEM.
    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = mem_addr_r;
        MEM_WRITEDATA = mem_wdata_r;
        if (RESET) begin
            MEM_ADDR      = '0;
            MEM_WRITEDATA = '0;
        end else if (state_r == ST_EXEC) begin
            MEM_READ  = is_load_s;
            MEM_WRITE = is_store_s;
            if (is_load_s || is_store_s) begin
                MEM_ADDR = addr_from_reg_s ? rs2_val_s : imm_s;
            end else begin
                MEM_ADDR = mem_addr_r;
            end
            if (is_store_s) begin
                MEM_WRITEDATA = rs1_val_s;
            end else begin
                MEM_WRITEDATA = mem_wdata_r;
            end
        end else begin
            MEM_READ  = acc_load_r;
            MEM_WRITE = acc_store_r;
        end
    end

    // Architectural state: register file, PC and execution FSM.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= '0;
            end
            state_r     <= ST_EXEC;
            pc_r        <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            acc_load_r  <= 1'b0;
            acc_store_r <= 1'b0;
            acc_rd_r    <= '0;
        end else begin
            case (state_r)
                ST_EXEC: begin
                    pc_r <= pc_plus4_s;
                    case (op_s)
                        OP_LOADI: regs_r[rd_idx_s] <= imm_s;
                        OP_MOV:   regs_r[rd_idx_s] <= rs2_val_s;
                        OP_ADD:   regs_r[rd_idx_s] <= rs1_val_s + rs2_val_s;
                        OP_SUB:   regs_r[rd_idx_s] <= rs1_val_s + (~rs2_val_s) + DATA_W'(1'b1);
                        OP_AND:   regs_r[rd_idx_s] <= rs1_val_s & rs2_val_s;
                        OP_OR:    regs_r[rd_idx_s] <= rs1_val_s | rs2_val_s;
                        OP_J:     pc_r <= br_target_s;
                        OP_BEQ:   pc_r <= (rs1_val_s == rs2_val_s) ? br_target_s : pc_plus4_s;
                        OP_BNE:   pc_r <= (rs1_val_s != rs2_val_s) ? br_target_s : pc_plus4_s;
                        OP_MULT: begin
                            pc_r     <= pc_r;
                            acc_rd_r <= rd_idx_s;
                            state_r  <= ST_MUL;
                        end
                        OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                            pc_r        <= pc_r;
                            acc_rd_r    <= rd_idx_s;
                            acc_load_r  <= is_load_s;
                            acc_store_r <= is_store_s;
                            mem_addr_r  <= addr_from_reg_s ? rs2_val_s : imm_s;
                            mem_wdata_r <= is_store_s ? rs1_val_s : mem_wdata_r;
                            state_r     <= ST_MEM;
                        end
                        default: pc_r <= pc_plus4_s;
                    endcase
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        regs_r[acc_rd_r] <= mul_product_s;
                        pc_r             <= pc_plus4_s;
                        state_r          <= ST_EXEC;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_MEM: begin
                    if (!MEM_BUSYWAIT) begin
                        if (acc_load_r) begin
                            regs_r[acc_rd_r] <= MEM_READDATA;
                        end else begin
                            regs_r[acc_rd_r] <= regs_r[acc_rd_r];
                        end
                        acc_load_r  <= 1'b0;
                        acc_store_r <= 1'b0;
                        pc_r        <= pc_plus4_s;
                        state_r     <= ST_EXEC;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                default: state_r <= ST_EXEC;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc.sv
// Randomised and directed bench for cpu_mc, checked against an
// instruction-level reference model that tracks cycles per instruction.
module tb_cpu_mc;
    import cpu_mc_pkg::*;

    localparam int NREG = 8;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [7:0]  MEM_ADDR;
    logic [7:0]  MEM_WRITEDATA;
    logic [7:0]  MEM_READDATA;
    logic        MEM_BUSYWAIT;

    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        mem_read2;
    logic        mem_write2;
    logic [15:0] mem_addr2;
    logic [15:0] mem_wdata2;

    logic [31:0] imem  [64];
    logic [31:0] imem2 [64];
    logic [31:0] prog_q [$];

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  rm [NREG];
    logic [31:0] pc_m;
    int          k_m;
    logic [7:0]  mem_seen  [256];
    logic [15:0] mem2_seen [256];
    int          wr10_cycles;
    int          pc2_at12;
    logic [31:0] pc_seen;
    int          bw_left = 0;
    bit          bw_rand = 1'b0;
    bit          rd_rand = 1'b0;
    logic [7:0]  rdata_fix = 8'h00;

    cpu_mc dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    cpu_mc #(.DATA_W(16), .REG_CNT(16), .PC_W(32)) dut16 (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr2), .PC(pc2),
        .MEM_READ(mem_read2), .MEM_WRITE(mem_write2), .MEM_ADDR(mem_addr2),
        .MEM_WRITEDATA(mem_wdata2), .MEM_READDATA(16'h0000),
        .MEM_BUSYWAIT(1'b0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign INSTRUCTION = imem[PC[7:2]];
    assign instr2      = imem2[pc2[7:2]];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] f2,
                                        input logic [7:0] f1, input logic [7:0] f0);
        return {op, f2, f1, f0};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 64; i++) begin
            imem[i] = (i < prog_q.size()) ? prog_q[i] : 32'hFF00_0000;
        end
        for (int i = 0; i < 256; i++) begin
            mem_seen[i] = 8'h5A;
        end
    endtask

    // Called at a negedge; asserts RESET between edges, checks the immediate
    // effect, holds it over one rising edge and releases at the next negedge.
    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        check_val("rst_pc", 64'(PC), 64'd0);
        check_val("rst_mem_read", 64'(MEM_READ), 64'd0);
        check_val("rst_mem_write", 64'(MEM_WRITE), 64'd0);
        check_val("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
        check_val("rst_mem_wdata", 64'(MEM_WRITEDATA), 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        pc_m = 32'd0;
        k_m  = 0;
        for (int i = 0; i < NREG; i++) rm[i] = 8'h00;
    endtask

    // One clock cycle: drive memory inputs, compare against the model, advance.
    task automatic step();
        logic [31:0] instr, tgt, nxt;
        logic [7:0]  op, rs1v, rs2v, imm, exp_addr;
        int          rd;
        bit          ld, st, done;
        if (bw_left > 0) begin
            MEM_BUSYWAIT = 1'b1;
            bw_left--;
        end else begin
            MEM_BUSYWAIT = bw_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        MEM_READDATA = rd_rand ? 8'($urandom) : rdata_fix;
        #1;
        instr    = imem[pc_m[7:2]];
        op       = instr[31:24];
        rd       = int'(instr[23:16]) % NREG;
        rs1v     = rm[int'(instr[15:8]) % NREG];
        rs2v     = rm[int'(instr[7:0]) % NREG];
        imm      = instr[7:0];
        ld       = (op == OP_LWD) || (op == OP_LWI);
        st       = (op == OP_SWD) || (op == OP_SWI);
        exp_addr = ((op == OP_LWD) || (op == OP_SWD)) ? rs2v : imm;
        tgt      = pc_m + 32'd4 + 32'(int'($signed(instr[23:16])) * 4);

        check_val("pc", 64'(PC), 64'(pc_m));
        check_val("mem_read", 64'(MEM_READ), 64'(ld));
        check_val("mem_write", 64'(MEM_WRITE), 64'(st));
        if (ld || st) check_val("mem_addr", 64'(MEM_ADDR), 64'(exp_addr));
        if (st) check_val("mem_wdata", 64'(MEM_WRITEDATA), 64'(rs1v));

        pc_seen = PC;
        if (MEM_WRITE) mem_seen[MEM_ADDR] = MEM_WRITEDATA;
        if (MEM_WRITE && MEM_ADDR == 8'h10) wr10_cycles++;
        if (mem_write2) mem2_seen[mem_addr2[7:0]] = mem_wdata2;
        if (pc2 == 32'd12) pc2_at12++;

        if (ld || st)          done = (k_m >= 1) && !MEM_BUSYWAIT;
        else if (op == OP_MULT) done = (k_m == 8);
        else                    done = 1'b1;

        if (done) begin
            nxt = pc_m + 32'd4;
            case (op)
                OP_LOADI: rm[rd] = imm;
                OP_MOV:   rm[rd] = rs2v;
                OP_ADD:   rm[rd] = 8'(int'(rs1v) + int'(rs2v));
                OP_SUB:   rm[rd] = 8'(int'(rs1v) - int'(rs2v));
                OP_AND:   rm[rd] = rs1v & rs2v;
                OP_OR:    rm[rd] = rs1v | rs2v;
                OP_J:     nxt = tgt;
                OP_BEQ:   if (rs1v == rs2v) nxt = tgt;
                OP_BNE:   if (rs1v != rs2v) nxt = tgt;
                OP_MULT:  rm[rd] = 8'(int'(rs1v) * int'(rs2v));
                OP_LWD, OP_LWI: rm[rd] = MEM_READDATA;
                default: ;
            endcase
            pc_m = nxt;
            k_m  = 0;
        end else begin
            k_m++;
        end
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] exp1 [5];
        logic [31:0] exp2 [7];
        logic [7:0]  op_r;
        int          sel;
        RESET        = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = 8'h00;
        for (int i = 0; i < 64; i++) imem2[i] = 32'hFF00_0000;
        for (int i = 0; i < 256; i++) mem2_seen[i] = 16'h5A5A;
        prog_q = {};
        load_prog();
        @(negedge CLK);

        // ALU sequence
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'd5), ins(OP_LOADI, 8'd2, 8'd0, 8'd3),
                  ins(OP_ADD, 8'd3, 8'd1, 8'd2), ins(OP_SUB, 8'd4, 8'd1, 8'd2),
                  ins(OP_SWI, 8'd0, 8'd3, 8'h20), ins(OP_SWI, 8'd0, 8'd4, 8'h21)};
        load_prog();
        do_reset();
        repeat (4) step();
        check_val("alu_pc16", 64'(PC), 64'd16);
        repeat (4) step();
        check_val("add_r3", 64'(mem_seen[8'h20]), 64'h08);
        check_val("sub_r4", 64'(mem_seen[8'h21]), 64'h02);

        // Multiply latency and PC hold
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'h0F), ins(OP_LOADI, 8'd2, 8'd0, 8'h11),
                  ins(OP_MULT, 8'd3, 8'd1, 8'd2), ins(OP_SWI, 8'd0, 8'd3, 8'h22)};
        load_prog();
        do_reset();
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            step();
            check_val("mul_pc_hold", 64'(pc_seen), 64'd8);
        end
        step();
        check_val("mul_pc_adv", 64'(pc_seen), 64'd12);
        repeat (2) step();
        check_val("mul_r3", 64'(mem_seen[8'h22]), 64'hFF);

        // beq taken backward, bne not taken, j forward
        prog_q = {ins(OP_J, 8'h01, 8'd0, 8'd0), ins(OP_BNE, 8'h7F, 8'd1, 8'd2),
                  ins(OP_BEQ, 8'hFE, 8'd1, 8'd2)};
        load_prog();
        do_reset();
        exp1 = '{32'd0, 32'd8, 32'd4, 32'd8, 32'd4};
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("br1_pc", 64'(pc_seen), 64'(exp1[i]));
        end

        // bne with equal regs, then backward jump across PC wrap
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'd0), 32'hFF00_0000,
                  ins(OP_BNE, 8'h40, 8'd1, 8'd2), ins(OP_J, 8'hFA, 8'd0, 8'd0)};
        load_prog();
        do_reset();
        exp2 = '{32'd0, 32'd4, 32'd8, 32'd12, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd0};
        for (int i = 0; i < 7; i++) begin
            step();
            check_val("br2_pc", 64'(pc_seen), 64'(exp2[i]));
        end

        // Store with busywait, then load back
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'hAA), ins(OP_SWI, 8'd0, 8'd1, 8'h10),
                  ins(OP_LWI, 8'd5, 8'd0, 8'h10), ins(OP_SWI, 8'd0, 8'd5, 8'h30)};
        load_prog();
        do_reset();
        wr10_cycles = 0;
        rdata_fix   = 8'hAA;
        step();
        bw_left = 3;
        repeat (4) step();
        check_val("sw_strobe_cycles", 64'(wr10_cycles), 64'd4);
        repeat (4) step();
        check_val("lw_r5", 64'(mem_seen[8'h30]), 64'hAA);
        rdata_fix = 8'h00;

        // Reset mid-MUL and mid-MEM, then confirm rd untouched
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'd3), ins(OP_MULT, 8'd3, 8'd1, 8'd1)};
        load_prog();
        do_reset();
        repeat (4) step();
        do_reset();
        prog_q = {ins(OP_LOADI, 8'd1, 8'd0, 8'd7), ins(OP_SWI, 8'd0, 8'd1, 8'h44)};
        load_prog();
        do_reset();
        step();
        bw_left = 10;
        repeat (3) step();
        do_reset();
        bw_left = 0;
        prog_q = {ins(OP_SWI, 8'd0, 8'd3, 8'h40), ins(OP_SWI, 8'd0, 8'd1, 8'h41)};
        load_prog();
        do_reset();
        repeat (4) step();
        check_val("abort_r3", 64'(mem_seen[8'h40]), 64'h00);
        check_val("abort_r1", 64'(mem_seen[8'h41]), 64'h00);

        // 16-bit instance: 300*200 and register 15
        imem2[0] = ins(OP_LOADI, 8'd1, 8'd0, 8'd150);
        imem2[1] = ins(OP_ADD, 8'd1, 8'd1, 8'd1);
        imem2[2] = ins(OP_LOADI, 8'd15, 8'd0, 8'd200);
        imem2[3] = ins(OP_MULT, 8'd14, 8'd1, 8'd15);
        imem2[4] = ins(OP_LOADI, 8'd7, 8'd0, 8'd1);
        imem2[5] = ins(OP_SWI, 8'd0, 8'd14, 8'h50);
        imem2[6] = ins(OP_SWI, 8'd0, 8'd15, 8'h51);
        do_reset();
        pc2_at12 = 0;
        repeat (30) step();
        check_val("w16_mul_cycles", 64'(pc2_at12), 64'd17);
        check_val("w16_product", 64'(mem2_seen[8'h50]), 64'hEA60);
        check_val("w16_r15", 64'(mem2_seen[8'h51]), 64'd200);

        // Random programs with random stalls, load data and resets
        bw_rand = 1'b1;
        rd_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            prog_q = {};
            for (int i = 0; i < 64; i++) begin
                sel  = $urandom_range(0, 14);
                op_r = (sel == 14) ? 8'hFF : 8'(sel);
                prog_q.push_back(ins(op_r, 8'($urandom), 8'($urandom), 8'($urandom)));
            end
            load_prog();
            do_reset();
            for (int c = 0; c < 400; c++) begin
                step();
                if ($urandom_range(0, 149) == 0) do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
